// File: rtl/pwm_fader_pkg.sv
// Shared types and constants for the PWM duty fader and its helpers.
// Contents: FSM state enum and the minimum effective step size.
package pwm_fader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } fader_state_t;

    // A requested step of 0 is applied as this value.
    localparam int unsigned STEP_MIN = 1;

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter; tick marks the last cycle of each period.
// Ports: clk, rst (sync, active-high), tick (high when counter is all ones).
module pwm_period_tick #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign tick = &r_cnt;

endmodule

// File: rtl/pwm_fader.sv
// Duty-cycle sequencer: ramps duty toward a requested target by a clamped
// step once every (dwell+1) PWM periods, updating only at period boundaries.
// Ports: clk, rst (sync, active-high); tgt_valid/tgt_ready handshake with
// tgt_duty/tgt_step/tgt_dwell; duty, busy, done outputs.
// Optional macro PWM_FADER_ABORT_EN adds input abort (cancel ramp, hold duty).
module pwm_fader
    import pwm_fader_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tgt_valid,
    output logic               tgt_ready,
    input  logic [WIDTH-1:0]   tgt_duty,
    input  logic [STEP_W-1:0]  tgt_step,
    input  logic [DWELL_W-1:0] tgt_dwell,
    output logic [WIDTH-1:0]   duty,
    output logic               busy,
    output logic               done
`ifdef PWM_FADER_ABORT_EN
    ,
    input  logic               abort
`endif
);

    localparam logic [DWELL_W-1:0] DWELL_ONE = 1;

    fader_state_t       r_state;
    logic [WIDTH-1:0]   r_duty;
    logic [WIDTH-1:0]   r_tgt;
    logic [STEP_W-1:0]  r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               r_done;

    logic               w_tick;
    logic               w_busy;
    logic               w_accept;
    logic               w_abort;
    logic               w_dwell_hit;
    logic               w_reach;
    logic [WIDTH:0]     w_step_x;
    logic [WIDTH:0]     w_gap;
    logic [WIDTH:0]     w_next;
    logic [WIDTH-1:0]   w_duty_nxt;

    pwm_period_tick #(
        .WIDTH(WIDTH)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(w_tick)
    );

    assign w_busy      = (r_state != ST_IDLE);
    assign tgt_ready   = (r_state == ST_IDLE) & ~rst;
    assign w_accept    = tgt_valid & tgt_ready;
    assign w_dwell_hit = (r_dwell_cnt == r_dwell);

`ifdef PWM_FADER_ABORT_EN
    assign w_abort = abort & w_busy;
`else
    assign w_abort = 1'b0;
`endif

    assign w_step_x = (r_step == '0) ? (WIDTH+1)'(STEP_MIN)
                                     : (WIDTH+1)'(r_step);

    // One extra bit keeps the distance and the unclamped sum exact, so the
    // clamp test never sees a wrapped value.
    always_comb begin
        w_gap  = '0;
        w_next = '0;
        if (r_state == ST_UP) begin
            w_gap  = {1'b0, r_tgt} - {1'b0, r_duty};
            w_next = {1'b0, r_duty} + w_step_x;
        end else begin
            w_gap  = {1'b0, r_duty} - {1'b0, r_tgt};
            w_next = {1'b0, r_duty} - w_step_x;
        end
        w_reach    = (w_gap <= w_step_x);
        w_duty_nxt = w_reach ? r_tgt : w_next[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_duty      <= '0;
            r_tgt       <= '0;
            r_step      <= '0;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_tgt       <= tgt_duty;
                r_step      <= tgt_step;
                r_dwell     <= tgt_dwell;
                r_dwell_cnt <= '0;
                if (tgt_duty > r_duty) begin
                    r_state <= ST_UP;
                end else if (tgt_duty < r_duty) begin
                    r_state <= ST_DOWN;
                end else begin
                    r_done <= 1'b1;
                end
            end else if (w_abort) begin
                // Abort beats a coincident tick: duty is left untouched.
                r_state <= ST_IDLE;
            end else if (w_busy && w_tick) begin
                // Written on the last cycle of a period, so the new duty
                // takes effect exactly when the PWM counter restarts.
                if (w_dwell_hit) begin
                    r_dwell_cnt <= '0;
                    r_duty      <= w_duty_nxt;
                    if (w_reach) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end else begin
                    r_dwell_cnt <= r_dwell_cnt + DWELL_ONE;
                end
            end
        end
    end

    assign duty = r_duty;
    assign busy = w_busy;
    assign done = r_done;

endmodule
